mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MAXBURST, default 4, maximum consecutive locked grants to one master while the other master is requesting.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req  input  1  master 0 (CPU port) access request, held until granted.
REQ-005 m0_we  input  1  master 0 write when 1, read when 0.
REQ-006 m0_lock  input  1  master 0 asks to keep ownership for the next cycle.
REQ-007 m0_adr  input  32  master 0 byte address.
REQ-008 m0_wdata  input  32  master 0 write data.
REQ-009 m0_gnt  output  1  master 0 access accepted this cycle.
REQ-010 m0_rvalid  output  1  master 0 read data valid.
REQ-011 m0_rdata  output  32  master 0 read data.
REQ-012 m1_req, m1_we, m1_lock, m1_adr[31:0], m1_wdata[31:0], m1_gnt, m1_rvalid, m1_rdata[31:0]: same as REQ-004..011 for master 1 (loader/debug port).
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_adr  output  32  memory address.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-018 At most one of m0_gnt/m1_gnt shall be 1 in any cycle; mi_gnt is combinational and only asserted when mi_req=1.
REQ-019 In a cycle with a grant: mem_en=1; mem_we, mem_adr, mem_wdata shall equal the granted master's inputs. With no grant: mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0.
REQ-020 Registered state: owner (NONE/M0/M1), ptr (1 bit, preferred master), burst counter (width clog2(MAXBURST)+1), rd_tag (valid + master id).
REQ-021 Owner NONE: a single requester is granted; if both request, the master selected by ptr is granted.
REQ-022 After every grant to master i, ptr shall become 1-i on the next edge.
REQ-023 Grant to master i with mi_lock=1 shall set owner=Mi on the next edge; mi_lock=0 shall set owner=NONE.
REQ-024 Owner Mi: master i has absolute priority if mi_req=1; if mi_req=0, owner reverts to NONE behaviour in the same cycle and owner becomes NONE next edge.
REQ-025 Burst counter increments on each grant while owner=Mi and resets to 0 whenever ownership changes or owner=NONE.
REQ-026 When owner=Mi, counter=MAXBURST-1 and the other master requests, the other master shall be granted that cycle and owner shall become NONE (or the other master, if it requests with lock).
REQ-027 A granted read sets rd_tag valid with master id; the next cycle asserts that master's mi_rvalid=1 for exactly one cycle. A granted write sets no rvalid.
REQ-028 mi_rdata shall equal mem_rdata when mi_rvalid=1 and 0 otherwise.
REQ-029 Back-to-back reads (also alternating masters) shall be sustained at one per cycle; each rvalid goes to the master granted one cycle earlier.
REQ-030 Requests while mi_gnt=0 shall be ignored; no internal queueing.

Reset
REQ-031 With rst=1 on an edge: owner=NONE, ptr=0, counter=0, rd_tag invalid; in the following cycle no rvalid, any in-flight read response discarded.
REQ-032 While rst=1, all gnt, rvalid, mem_* outputs shall be 0 and rdata outputs 0.

Verification
REQ-033 After reset, m0_req=m1_req=1 (reads, adr 0x10/0x20, no lock) for 4 cycles -> grants M0,M1,M0,M1; mem_adr 0x10,0x20,0x10,0x20; rvalids follow one cycle later to the same masters.
REQ-034 m1 read adr 0x40 alone -> m1_gnt=1, mem_en=1, mem_we=0; next cycle m1_rvalid=1, m1_rdata=mem_rdata (e.g., 0xDEADBEEF); m0_rvalid=0.
REQ-035 m0 write adr 0x8 data 0x1234 -> mem_we=1, mem_wdata=0x1234; no rvalid in the following cycle.
REQ-036 m0 holds req+lock, m1 requesting continuously, MAXBURST=4 -> m0 granted 3 cycles, m1 granted on the 4th, counter back to 0.
REQ-037 m0 read granted, rst=1 on the next edge -> m0_rvalid stays 0; all outputs 0 while rst=1; first post-reset simultaneous request is granted to M0.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bundle of the two master ports, the memory port and arbiter debug state.
// "slave" is the arbiter side; "master" is whatever drives the requests and models memory.
interface mem_arb_if #(
  parameter int MAXBURST = 4
);
  localparam int CW = $clog2(MAXBURST) + 1;

  logic        m0_req;
  logic        m0_we;
  logic        m0_lock;
  logic [31:0] m0_adr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic        m1_lock;
  logic [31:0] m1_adr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [1:0]    dbg_owner;
  logic          dbg_ptr;
  logic [CW-1:0] dbg_cnt;

  // Handshake: a master holds req (with we/lock/adr/wdata stable) until gnt=1 in the
  // same cycle; gnt is the acceptance. A granted read returns rvalid+rdata exactly one
  // cycle later; there is no backpressure on the response.
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_adr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_adr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata,
    output dbg_owner, dbg_ptr, dbg_cnt
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_adr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_adr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata,
    input  dbg_owner, dbg_ptr, dbg_cnt
  );
endinterface

// File: rtl/mem_arb.sv
// Two-master single-port memory arbiter: round-robin when idle, lock-based ownership
// with a bounded burst, and one-cycle read response routing.
module mem_arb #(
  parameter int MAXBURST = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);
  localparam int CW = $clog2(MAXBURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXBURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t        owner, owner_nxt;
  logic          ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tag_v, tag_v_nxt;
  logic          tag_id, tag_id_nxt;

  logic gnt0, gnt1, grant, gid, glock, gwe, burst_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= OWN_NONE;
      ptr    <= 1'b0;
      cnt    <= '0;
      tag_v  <= 1'b0;
      tag_id <= 1'b0;
    end else begin
      owner  <= owner_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      tag_v  <= tag_v_nxt;
      tag_id <= tag_id_nxt;
    end
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    burst_full = (cnt >= CNT_LAST);
    // An owner without a request falls through to plain round-robin arbitration.
    if (!rst) begin
      if (owner == OWN_M0 && bus.m0_req) begin
        if (burst_full && bus.m1_req) gnt1 = 1'b1;
        else                          gnt0 = 1'b1;
      end else if (owner == OWN_M1 && bus.m1_req) begin
        if (burst_full && bus.m0_req) gnt0 = 1'b1;
        else                          gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end

    grant = gnt0 | gnt1;
    gid   = gnt1;
    glock = gnt1 ? bus.m1_lock : bus.m0_lock;
    gwe   = gnt1 ? bus.m1_we   : bus.m0_we;

    owner_nxt  = OWN_NONE;
    ptr_nxt    = ptr;
    cnt_nxt    = '0;
    tag_v_nxt  = 1'b0;
    tag_id_nxt = tag_id;
    if (grant) begin
      ptr_nxt    = ~gid;
      tag_v_nxt  = ~gwe;
      tag_id_nxt = gid;
      if (glock) begin
        owner_nxt = gid ? OWN_M1 : OWN_M0;
        // Only a continued locked grant to the current owner extends the burst.
        if (owner == owner_nxt) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end
    end
  end

  always_comb begin
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.mem_en    = grant;
    bus.mem_we    = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_wdata = '0;
    if (gnt0) begin
      bus.mem_we    = bus.m0_we;
      bus.mem_adr   = bus.m0_adr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (gnt1) begin
      bus.mem_we    = bus.m1_we;
      bus.mem_adr   = bus.m1_adr;
      bus.mem_wdata = bus.m1_wdata;
    end
    bus.m0_rvalid = !rst && tag_v && !tag_id;
    bus.m1_rvalid = !rst && tag_v &&  tag_id;
    bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
    bus.dbg_owner = owner;
    bus.dbg_ptr   = ptr;
    bus.dbg_cnt   = cnt;
  end
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus random traffic, all checked by a
// scoreboard fed from a transaction-level model of the arbitration rules.
module tb_mem_arb;
  localparam int MAXBURST = 4;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        en;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if #(.MAXBURST(MAXBURST)) bus ();
  mem_arb #(.MAXBURST(MAXBURST)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: -1 means "none".
  int own = -1;
  int cnt = 0;
  int ptr = 0;
  int rdm = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit [1:0] req, input bit [1:0] we, input bit [1:0] lk,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] mrd);
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    rst = r;
    bus.m0_req = req[0]; bus.m0_we = we[0]; bus.m0_lock = lk[0];
    bus.m0_adr = a0;     bus.m0_wdata = d0;
    bus.m1_req = req[1]; bus.m1_we = we[1]; bus.m1_lock = lk[1];
    bus.m1_adr = a1;     bus.m1_wdata = d1;
    bus.mem_rdata = mrd;

    e = '0;
    g = -1;
    if (!r) begin
      if (own >= 0 && req[own])
        g = (cnt >= MAXBURST - 1 && req[1-own]) ? 1 - own : own;
      else if (req == 2'b11) g = ptr;
      else if (req[0])       g = 0;
      else if (req[1])       g = 1;
      if (rdm == 0) begin e.rv0 = 1'b1; e.rd0 = mrd; end
      if (rdm == 1) begin e.rv1 = 1'b1; e.rd1 = mrd; end
    end
    if (g >= 0) begin
      e.g0  = (g == 0);
      e.g1  = (g == 1);
      e.en  = 1'b1;
      e.we  = we[g];
      e.adr = (g == 0) ? a0 : a1;
      e.wd  = (g == 0) ? d0 : d1;
    end
    exp_q.push_back(e);

    if (r) begin
      own = -1; cnt = 0; ptr = 0; rdm = -1;
    end else if (g >= 0) begin
      cnt = (own == g && lk[g]) ? ((cnt < MAXBURST) ? cnt + 1 : cnt) : 0;
      own = lk[g] ? g : -1;
      ptr = 1 - g;
      rdm = we[g] ? -1 : g;
    end else begin
      own = -1; cnt = 0; rdm = -1;
    end
  endtask

  task automatic idle(input logic [31:0] mrd);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0, mrd);
  endtask

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'({e.g0, e.g1}));
        chk("sb_mem_ctl", 32'({bus.mem_en, bus.mem_we}), 32'({e.en, e.we}));
        chk("sb_mem_adr", bus.mem_adr, e.adr);
        chk("sb_mem_wdata", bus.mem_wdata, e.wd);
        chk("sb_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'({e.rv0, e.rv1}));
        chk("sb_rdata0", bus.m0_rdata, e.rd0);
        chk("sb_rdata1", bus.m1_rdata, e.rd1);
      end
    end
  end

  initial begin
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_adr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_adr = '0; bus.m1_wdata = '0;
    bus.mem_rdata = '0;

    // Reset with both masters requesting: everything stays quiet.
    cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, '0, '0, 32'hFFFF_FFFF);
    cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, '0, '0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
    chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);

    // Alternating reads from both masters, responses one cycle later.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, '0, '0, 32'hA000_0000 + k);
      else       idle(32'hA000_0004);
      @(negedge clk);
      if (k < 4) begin
        chk("rr_gnt0", 32'(bus.m0_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_adr", bus.mem_adr, (k % 2 == 0) ? 32'h10 : 32'h20);
      end
      if (k > 0) begin
        chk("rr_rvalid0", 32'(bus.m0_rvalid), ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_rvalid1", 32'(bus.m1_rvalid), ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
      end
    end

    // Lone m1 read.
    cyc(1'b0, 2'b10, 2'b00, 2'b00, '0, 32'h40, '0, '0, '0);
    @(negedge clk);
    chk("m1rd_gnt", 32'({bus.m1_gnt, bus.mem_en, bus.mem_we}), 32'b110);
    idle(32'hDEAD_BEEF);
    @(negedge clk);
    chk("m1rd_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'b01);
    chk("m1rd_rdata", bus.m1_rdata, 32'hDEAD_BEEF);

    // m0 write: no read response afterwards.
    cyc(1'b0, 2'b01, 2'b01, 2'b00, 32'h8, '0, 32'h1234, '0, '0);
    @(negedge clk);
    chk("m0wr_we", 32'({bus.m0_gnt, bus.mem_we}), 32'b11);
    chk("m0wr_wdata", bus.mem_wdata, 32'h1234);
    idle(32'h5555_5555);
    @(negedge clk);
    chk("m0wr_norv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);

    // Locked burst: m0 takes ownership, then m1 contends and wins after the burst.
    cyc(1'b0, 2'b01, 2'b00, 2'b01, 32'h100, 32'h200, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'b11, 2'b00, 2'b01, 32'h104 + 32'(k), 32'h200, '0, '0, 32'(k));
      @(negedge clk);
      chk("burst_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), (k < 3) ? 32'b10 : 32'b01);
    end
    idle('0);
    @(negedge clk);
    chk("burst_cnt", 32'(bus.dbg_cnt), 32'd0);
    chk("burst_owner", 32'(bus.dbg_owner), 32'd0);

    // A read in flight when reset hits must never deliver rvalid.
    cyc(1'b0, 2'b01, 2'b00, 2'b00, 32'h300, '0, '0, '0, '0);
    cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h300, 32'h400, '0, '0, 32'h1111_1111);
    @(negedge clk);
    chk("rstrd_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
    chk("rstrd_outs", 32'({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we}), 32'd0);
    cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h300, 32'h400, '0, '0, 32'h2222_2222);
    @(negedge clk);
    chk("rstrd_first", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    chk("rstrd_norv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);

    // Random traffic, mostly contended so locked bursts get exercised.
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] rq;
      rq = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      cyc(($urandom_range(0, 63) == 0), rq, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
